// File: rtl/usb_rst_sequencer_if.sv
// usb_rst_sequencer_if: Avalon-MM slave bus bundle for the USB reset sequencer.
interface usb_rst_sequencer_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    modport master (output address, chipselect, write_n, writedata, input readdata);
    modport slave (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/usb_rst_sequencer.sv
// usb_rst_sequencer: Avalon-MM sequencer timing the USB chip reset pulse and settle interval.
// Define USB_RST_IRQ_EN to add the registered completion interrupt (irq port, CONTROL bit2).
module usb_rst_sequencer #(
    parameter int               CNT_W      = 16,
    parameter logic [CNT_W-1:0] DEF_PULSE  = 16'd50000,
    parameter logic [CNT_W-1:0] DEF_SETTLE = 16'd25000,
    parameter bit               AUTO_START = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    usb_rst_sequencer_if.slave  bus,
    output logic                usb_rst_n,
    output logic                usb_ready
`ifdef USB_RST_IRQ_EN
    ,
    output logic                irq
`endif
);
    typedef enum logic [1:0] {IDLE, ASSERT, SETTLE, READY} state_t;
    state_t state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d, pulse_len, settle_len;
    logic force_q, done, start_q, first_q, irq_en;
    logic wr, busy, set_done, launch, start_acc, unused_wd;

    assign wr = bus.chipselect && !bus.write_n;
    assign busy = state == ASSERT || state == SETTLE;
    assign launch = state_d == ASSERT && state != ASSERT;
    // A START landing on the completing edge is kept and launched from READY.
    assign start_acc = wr && bus.address == 2'd0 && bus.writedata[0] && !bus.writedata[1]
                       && !force_q && (!busy || set_done);
    assign unused_wd = ^bus.writedata[31:CNT_W];

    always_comb begin
        state_d = state;
        cnt_d = cnt;
        set_done = 1'b0;
        if (force_q)
            state_d = IDLE;
        else
            case (state)
                IDLE, READY: if (start_q) begin
                    state_d = ASSERT;
                    cnt_d = pulse_len;
                end
                ASSERT: if (cnt > CNT_W'(1))
                    cnt_d = cnt - CNT_W'(1);
                else if (settle_len == '0) begin
                    state_d = READY;
                    set_done = 1'b1;
                end else begin
                    state_d = SETTLE;
                    cnt_d = settle_len;
                end
                default: if (cnt > CNT_W'(1))
                    cnt_d = cnt - CNT_W'(1);
                else begin
                    state_d = READY;
                    set_done = 1'b1;
                end
            endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt <= '0;
            pulse_len <= DEF_PULSE;
            settle_len <= DEF_SETTLE;
            force_q <= 1'b0;
            done <= 1'b0;
            start_q <= 1'b0;
            first_q <= 1'b1;
            usb_rst_n <= 1'b0;
            usb_ready <= 1'b0;
        end else begin
            state <= state_d;
            cnt <= cnt_d;
            first_q <= 1'b0;
            start_q <= start_acc || (AUTO_START && first_q && !force_q);
            done <= set_done || (done && !launch && !(wr && bus.address == 2'd3 && bus.writedata[1]));
            usb_rst_n <= state_d == SETTLE || state_d == READY;
            usb_ready <= state_d == READY;
            if (wr && bus.address == 2'd0) force_q <= bus.writedata[1];
            if (wr && bus.address == 2'd1) pulse_len <= bus.writedata[CNT_W-1:0];
            if (wr && bus.address == 2'd2) settle_len <= bus.writedata[CNT_W-1:0];
        end
    end

`ifdef USB_RST_IRQ_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_en <= 1'b0;
            irq <= 1'b0;
        end else begin
            if (wr && bus.address == 2'd0) irq_en <= bus.writedata[2];
            irq <= done && irq_en;
        end
    end
`else
    assign irq_en = 1'b0;
`endif

    assign bus.readdata = bus.address == 2'd0 ? {29'd0, irq_en, force_q, 1'b0}
                        : bus.address == 2'd1 ? 32'(pulse_len)
                        : bus.address == 2'd2 ? 32'(settle_len)
                        : {28'd0, state, done, busy};
endmodule

// File: tb/tb_usb_rst_sequencer.sv
// tb_usb_rst_sequencer: table-driven check of the USB reset sequencer plus corner-case sequences.
module tb_usb_rst_sequencer;
    typedef struct {
        bit        wr;
        bit [1:0]  addr;
        bit [31:0] wd;
        bit        rst_n;
        bit        ready;
        bit [31:0] st;
    } vec_t;

    logic clk, reset, usb_rst_n, usb_ready;
`ifdef USB_RST_IRQ_EN
    logic irq;
    localparam logic [31:0] CTRL_IRQ = 32'h4;
`else
    localparam logic [31:0] CTRL_IRQ = 32'h0;
`endif
    int checks = 0;
    int failures = 0;
    vec_t vq[$];

    usb_rst_sequencer_if bus();

    usb_rst_sequencer #(
        .CNT_W(16), .DEF_PULSE(16'd4), .DEF_SETTLE(16'd3), .AUTO_START(1'b1)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus), .usb_rst_n(usb_rst_n), .usb_ready(usb_ready)
`ifdef USB_RST_IRQ_EN
        , .irq(irq)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic add(bit wr, bit [1:0] addr, bit [31:0] wd, bit rst_n, bit ready, bit [31:0] st);
        vq.push_back('{wr, addr, wd, rst_n, ready, st});
    endtask

    task automatic idle(int n, bit rst_n, bit ready, bit [31:0] st);
        for (int k = 0; k < n; k++) add(1'b0, 2'd3, 32'd0, rst_n, ready, st);
    endtask

    task automatic write(bit [1:0] addr, bit [31:0] wd);
        bus.address = addr;
        bus.writedata = wd;
        bus.chipselect = 1'b1;
        bus.write_n = 1'b0;
        tick();
        bus.chipselect = 1'b0;
        bus.write_n = 1'b1;
        bus.address = 2'd3;
    endtask

    task automatic read(string name, bit [1:0] addr, logic [31:0] exp);
        bus.address = addr;
        #1;
        chk(name, bus.readdata, exp);
        bus.address = 2'd3;
    endtask

    initial begin
        // auto-started sequence with P=4, S=3
        idle(1, 0, 0, 0); idle(4, 0, 0, 5); idle(3, 1, 0, 9); idle(1, 1, 1, 14);
        // zero lengths: one ASSERT cycle, then straight to READY
        add(1, 1, 0, 1, 1, 14); add(1, 2, 0, 1, 1, 14); add(1, 0, 1, 1, 1, 14);
        idle(1, 0, 0, 5); idle(1, 1, 1, 14);
        // P=S=2; START inside SETTLE ignored
        add(1, 1, 2, 1, 1, 14); add(1, 2, 2, 1, 1, 14); add(1, 0, 1, 1, 1, 14);
        idle(2, 0, 0, 5); idle(1, 1, 0, 9); add(1, 0, 1, 1, 0, 9); idle(2, 1, 1, 14);
        // START on the SETTLE->READY edge launches from READY
        add(1, 0, 1, 1, 1, 14); idle(2, 0, 0, 5); idle(2, 1, 0, 9);
        add(1, 0, 1, 1, 1, 14); idle(1, 0, 0, 5);
        // FORCE mid-ASSERT, START+FORCE ignored, no auto-start after release
        add(1, 0, 2, 0, 0, 5); idle(1, 0, 0, 0); add(1, 0, 3, 0, 0, 0); add(1, 0, 0, 0, 0, 0);
        idle(2, 0, 0, 0); add(1, 0, 1, 0, 0, 0); idle(2, 0, 0, 5); idle(2, 1, 0, 9);
        idle(1, 1, 1, 14); add(1, 3, 2, 1, 1, 12);
        // W1C of DONE on the setting edge: set wins
        add(1, 0, 1, 1, 1, 12); idle(2, 0, 0, 5); idle(2, 1, 0, 9); add(1, 3, 2, 1, 1, 14);

        reset = 1'b1;
        bus.chipselect = 1'b0;
        bus.write_n = 1'b1;
        bus.address = 2'd3;
        bus.writedata = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_rst_n", 32'(usb_rst_n), 32'd0);
        chk("reset_ready", 32'(usb_ready), 32'd0);
        read("reset_status", 2'd3, 32'd0);
        read("reset_pulse", 2'd1, 32'd4);
        reset = 1'b0;

        foreach (vq[i]) begin
            bus.address = vq[i].addr;
            bus.writedata = vq[i].wd;
            bus.chipselect = vq[i].wr;
            bus.write_n = !vq[i].wr;
            tick();
            bus.chipselect = 1'b0;
            bus.write_n = 1'b1;
            bus.address = 2'd3;
            #1;
            chk($sformatf("row%0d_rst_n", i), 32'(usb_rst_n), 32'(vq[i].rst_n));
            chk($sformatf("row%0d_ready", i), 32'(usb_ready), 32'(vq[i].ready));
            chk($sformatf("row%0d_status", i), bus.readdata, vq[i].st);
        end

        // interrupt enable and timing
        write(2'd3, 32'h2);
        write(2'd0, 32'h4);
        read("ctrl_irq_en", 2'd0, CTRL_IRQ);
        write(2'd0, 32'h5);
        repeat (5) tick();
        chk("irq_seq_ready", 32'(usb_ready), 32'd1);
        read("irq_seq_status", 2'd3, 32'he);
`ifdef USB_RST_IRQ_EN
        chk("irq_before", 32'(irq), 32'd0);
        tick();
        chk("irq_rise", 32'(irq), 32'd1);
        write(2'd3, 32'h2);
        chk("irq_hold", 32'(irq), 32'd1);
        tick();
        chk("irq_clear", 32'(irq), 32'd0);
`endif

        // asynchronous reset during SETTLE
        write(2'd0, 32'h1);
        repeat (3) tick();
        chk("pre_reset_rst_n", 32'(usb_rst_n), 32'd1);
        read("pre_reset_status", 2'd3, 32'h9);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_n", 32'(usb_rst_n), 32'd0);
        chk("async_ready", 32'(usb_ready), 32'd0);
        read("async_status", 2'd3, 32'd0);
        read("async_pulse", 2'd1, 32'd4);
        read("async_settle", 2'd2, 32'd3);
        read("async_ctrl", 2'd0, 32'd0);
`ifdef USB_RST_IRQ_EN
        chk("async_irq", 32'(irq), 32'd0);
`endif
        tick();
        reset = 1'b0;
        tick();
        read("restart_idle", 2'd3, 32'd0);
        tick();
        read("restart_assert", 2'd3, 32'd5);
        chk("restart_rst_n", 32'(usb_rst_n), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/usb_rst_sequencer.md
# usb_rst_sequencer

Avalon-MM slave that sequences the reset line of the external USB controller chip. Software programs a reset pulse width and a post-reset settle time, then triggers a sequence. The block drives the chip's active-low reset pin, times both intervals, and reports completion through a status register and an optional interrupt. It sits on the system interconnect beside the other PIO-style slaves and replaces direct software bit-banging of the USB reset pin.

## Interface
Parameters:
- CNT_W, 16: width of the pulse and settle counters and their registers (2..31).
- DEF_PULSE, 16'd50000: reset value of PULSE_LEN (1 ms at 50 MHz).
- DEF_SETTLE, 16'd25000: reset value of SETTLE_LEN.
- AUTO_START, 1: when 1, a sequence starts automatically on the first clock after reset deasserts.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- address  in  2  register select.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe; a write occurs when chipselect && !write_n.
- writedata  in  32  write data.
- readdata  out  32  combinational read mux of the register at address; unused bits are 0.
- usb_rst_n  out  1  registered reset pin to the USB chip, active low.
- usb_ready  out  1  registered; 1 when the chip is out of reset and settled.
- irq  out  1  completion interrupt. Present only with USB_RST_IRQ_EN.

## Operation
Register map:
- 0 CONTROL: W bit0 START (self-clearing, reads 0); bit1 FORCE (level, R/W); bit2 IRQ_EN (R/W).
- 1 PULSE_LEN: R/W, bits [CNT_W-1:0].
- 2 SETTLE_LEN: R/W, bits [CNT_W-1:0].
- 3 STATUS: R bit0 BUSY, bit1 DONE (sticky), bits[3:2] state encoding. Writing 1 to bit1 clears DONE.

The state machine has four states with encodings IDLE=0, ASSERT=1, SETTLE=2, READY=3:
- IDLE: usb_rst_n=0 and usb_ready=0. A START, or the AUTO_START trigger, moves it to ASSERT.
- ASSERT: the counter loads PULSE_LEN on entry. usb_rst_n=0. The state leaves when the counter has spent max(PULSE_LEN,1) cycles in ASSERT, then goes to SETTLE.
- SETTLE: the counter loads SETTLE_LEN on entry. usb_rst_n=1. The state lasts max(SETTLE_LEN,0) cycles; a value of 0 goes straight to READY. On exit DONE is set to 1.
- READY: usb_rst_n=1 and usb_ready=1. A START moves it to ASSERT; a re-reset is permitted.

Rules:
- BUSY = (state==ASSERT || state==SETTLE).
- START while BUSY is ignored and has no side effects.
- START clears DONE.
- Writes to PULSE_LEN or SETTLE_LEN while BUSY update the register but take effect only at the next counter load.
- FORCE=1 takes priority from any state: go to IDLE, usb_rst_n=0, hold there while FORCE=1.
- START in the same write as FORCE=1 is ignored.
- Clearing FORCE does not auto-start; IDLE waits for START.
- A simultaneous START write and the SETTLE→READY transition: DONE is set, and the START applies the next cycle from READY.
- A write-1-to-clear of DONE coinciding with the setting of DONE: set wins.

## Timing
- Reset values:
  - state=IDLE, usb_rst_n=0, usb_ready=0, irq=0, DONE=0, FORCE=0, IRQ_EN=0.
  - PULSE_LEN=DEF_PULSE, SETTLE_LEN=DEF_SETTLE.
- Reset asserted mid-sequence: all outputs return to reset values immediately (asynchronously).
- START written at edge N: state=ASSERT and usb_rst_n=0 after edge N+1 (state and pins registered).
- usb_rst_n rises max(PULSE_LEN,1) cycles after ASSERT is entered.
- usb_ready rises SETTLE_LEN cycles after usb_rst_n rises.
- From a START write in IDLE, usb_ready rises at edge N+1+max(P,1)+S.
- AUTO_START: the first edge after reset release acts as the START edge N.
- readdata is zero-wait and reflects register state as of the current cycle.

## Configuration
- USB_RST_IRQ_EN defined:
  - The irq port exists.
  - irq is registered: irq = DONE && IRQ_EN, rising the cycle after DONE sets.
  - irq clears on the cycle after DONE is cleared or IRQ_EN is written 0.
- Undefined:
  - The irq port and its register are absent.
  - CONTROL bit2 reads 0 and ignores writes.
  - All other behaviour is identical.

## Test plan
- AUTO_START=1, PULSE_LEN=4, SETTLE_LEN=3 set via parameters -> after reset release, usb_rst_n low for exactly 4 cycles, high 3 cycles before usb_ready=1; STATUS reads 0xE.
- AUTO_START=0; write PULSE_LEN=0, SETTLE_LEN=0, then START -> ASSERT lasts 1 cycle, READY entered immediately after; DONE=1.
- Write START during SETTLE -> the sequence completes unchanged. Write START in READY -> usb_rst_n drops at the next edge, DONE clears.
- Write FORCE=1 mid-ASSERT -> state IDLE, usb_rst_n stays 0, START ignored. Write FORCE=0 -> remains IDLE until START.
- With USB_RST_IRQ_EN and IRQ_EN=1 -> irq rises 1 cycle after DONE. Write 0x2 to STATUS -> DONE and irq clear.
- Assert reset during SETTLE -> usb_rst_n=0, usb_ready=0 immediately; registers return to defaults.
